// File: rtl/mem_bus_responder.sv
// Memory-side responder for the cache/TLB line bus. It takes line writes and reads on the
// request channel and streams read lines beat-by-beat from a word-addressed backing store.
module mem_bus_responder #(
  parameter int ADDRESS_WIDTH = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int TAG_WIDTH     = 13,
  parameter int LINE_BEATS    = 8,
  parameter int MEM_WORDS     = 4096,
  parameter int READ_LATENCY  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     bus_reqcyc,
  output logic                     bus_reqack,
  input  logic [ADDRESS_WIDTH-1:0] bus_req,
  input  logic [TAG_WIDTH-1:0]     bus_reqtag,
  output logic                     bus_respcyc,
  input  logic                     bus_respack,
  output logic [DATA_WIDTH-1:0]    bus_resp,
  output logic [TAG_WIDTH-1:0]     bus_resptag,
  output logic [1:0]               o_dbg_state
);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam int WB     = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_RD_WAIT, S_RD_RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_reqack;
  logic                  r_respcyc;
  logic [DATA_WIDTH-1:0] r_resp;
  logic [TAG_WIDTH-1:0]  r_resptag;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [IDX_W-1:0]      r_base_idx;
  logic [BEAT_W-1:0]     r_beat;
  logic [LAT_W-1:0]      r_lat;
  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic                  w_sample;
  logic                  w_last_beat;
  logic                  w_lat_done;
  logic                  w_resp_adv;
  logic                  w_wr_en;
  logic [BEAT_W-1:0]     w_next_beat;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [IDX_W-1:0]      w_req_line_idx;

  // A beat is taken only while its ack is low, so a held beat is never sampled twice.
  assign w_sample       = bus_reqcyc & ~r_reqack & ((r_state == S_IDLE) | (r_state == S_WR_DATA));
  assign w_last_beat    = (r_beat == BEAT_W'(LINE_BEATS - 1));
  assign w_lat_done     = (r_lat == LAT_W'(READ_LATENCY - 1));
  assign w_resp_adv     = (r_state == S_RD_RESP) & r_respcyc & bus_respack;
  assign w_wr_en        = (r_state == S_WR_DATA) & w_sample;
  assign w_next_beat    = r_beat + BEAT_W'(1);
  assign w_wr_idx       = r_base_idx + IDX_W'(r_beat);
  assign w_rd_idx       = r_base_idx + IDX_W'(w_next_beat);
  assign w_req_line_idx = {bus_req[IDX_W+WB-1:WB+BEAT_W], BEAT_W'(0)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_sample) w_next = bus_reqtag[TAG_WIDTH-1] ? S_WR_DATA : S_RD_WAIT;
      S_WR_DATA: if (w_sample && w_last_beat) w_next = S_IDLE;
      S_RD_WAIT: if (w_lat_done) w_next = S_RD_RESP;
      S_RD_RESP: if (w_resp_adv && w_last_beat) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reqack   <= 1'b0;
      r_respcyc  <= 1'b0;
      r_resp     <= '0;
      r_resptag  <= '0;
      r_tag      <= '0;
      r_base_idx <= '0;
      r_beat     <= '0;
      r_lat      <= '0;
    end else begin
      r_reqack <= w_sample;
      case (r_state)
        S_IDLE: begin
          if (w_sample) begin
            r_base_idx <= w_req_line_idx;
            r_tag      <= bus_reqtag;
            r_beat     <= '0;
            r_lat      <= '0;
          end
        end
        S_WR_DATA: begin
          if (w_sample) r_beat <= w_next_beat;
        end
        S_RD_WAIT: begin
          if (w_lat_done) begin
            r_resp    <= r_mem[r_base_idx];
            r_respcyc <= 1'b1;
            r_resptag <= r_tag;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        S_RD_RESP: begin
          if (w_resp_adv) begin
            if (w_last_beat) begin
              r_respcyc <= 1'b0;
            end else begin
              r_beat <= w_next_beat;
              r_resp <= r_mem[w_rd_idx];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Backing store is intentionally not reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= bus_req[DATA_WIDTH-1:0];
  end

  assign bus_reqack  = r_reqack;
  assign bus_respcyc = r_respcyc;
  assign bus_resp    = r_resp;
  assign bus_resptag = r_resptag;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a table of line writes/reads with hand-computed
// expected data, plus hand sequences for reset, back-pressure and request collisions.
module tb_mem_bus_responder;
  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_reqcyc = 1'b0;
  logic        bus_reqack;
  logic [63:0] bus_req = '0;
  logic [12:0] bus_reqtag = '0;
  logic        bus_respcyc;
  logic        bus_respack = 1'b0;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic [1:0]  o_dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ack_cnt = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [12:0] tag;
    logic [63:0] seed;     // write: beat 0 data; read: expected beat 0 data
    logic [12:0] exp_tag;
    int          stall_beat;
  } vec_t;

  vec_t vecs[9];

  mem_bus_responder dut (
    .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_reqack) ack_cnt <= ack_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present one request beat and wait for its ack
  task automatic send_beat(input logic [63:0] d, input logic [12:0] tag, output int ack_c);
    bit got = 0;
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = tag;
    ack_c      = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus_reqack) begin
        ack_c = cyc;
        got   = 1;
        break;
      end
    end
    check("ack_seen", 64'(got), 64'd1);
  endtask

  task automatic write_data(input logic [63:0] seed, input logic [12:0] tag, input int n);
    int c;
    for (int i = 0; i < n; i++) send_beat(seed + 64'(i), tag, c);
  endtask

  // reqcyc stays high from the address beat through the last data beat
  task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input logic [63:0] seed);
    int a0, c;
    a0 = ack_cnt;
    send_beat(addr, tag, c);
    write_data(seed, tag, 8);
    bus_reqcyc = 1'b0;
    @(posedge clk); #1;
    check("wr_ack_count", 64'(ack_cnt - a0), 64'd9);
    check("wr_back_idle", 64'(o_dbg_state), 64'd0);
  endtask

  task automatic push_line(input logic [63:0] seed);
    for (int i = 0; i < 8; i++) exp_q.push_back(seed + 64'(i));
  endtask

  // scoreboard-checked read; caller pushes the 8 expected beats first
  task automatic read_line(input logic [63:0] addr, input logic [12:0] tag, input logic [12:0] exp_tag,
                           input int stall_beat, input bit collide);
    int ack_c, first_c, last_c, beat, stall, guard;
    send_beat(addr, tag, ack_c);
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    beat = 0; stall = 0; guard = 0; first_c = -1; last_c = -1;
    while (beat < 8 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
      if (bus_respcyc) begin
        if (first_c < 0) begin
          first_c = cyc;
          check("rd_first_latency", 64'(first_c - ack_c), 64'(RL));
        end
        if (collide) begin
          bus_reqcyc = 1'b1;
          bus_req    = 64'h5000;
          bus_reqtag = 13'h1007;
          check("collide_no_ack", 64'(bus_reqack), 64'd0);
        end
        check("rd_data", bus_resp, exp_q[0]);
        check("rd_tag", 64'(bus_resptag), 64'(exp_tag));
        if (beat == stall_beat && stall < 3) begin
          bus_respack = 1'b0;
          stall++;
        end else begin
          bus_respack = 1'b1;
          void'(exp_q.pop_front());
          beat++;
          last_c = cyc;
        end
      end else begin
        bus_respack = 1'b0;
      end
    end
    check("rd_beats", 64'(beat), 64'd8);
    @(posedge clk); #1;
    bus_respack = 1'b0;
    check("rd_respcyc_drop", 64'(bus_respcyc), 64'd0);
    if (stall_beat < 0) check("rd_last_beat_cycle", 64'(last_c - ack_c), 64'(RL + 7));
    else                check("rd_stall_cycles", 64'(stall), 64'd3);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reqack"}, 64'(bus_reqack), 64'd0);
    check({tag, "_respcyc"}, 64'(bus_respcyc), 64'd0);
    check({tag, "_resp"}, bus_resp, 64'd0);
    check({tag, "_resptag"}, 64'(bus_resptag), 64'd0);
    check({tag, "_state"}, 64'(o_dbg_state), 64'd0);
  endtask

  initial begin
    int c;
    vecs[0] = '{1'b1, 64'h1040, 13'h1005, 64'hA0, 13'h0000, -1};
    vecs[1] = '{1'b0, 64'h1078, 13'h0005, 64'hA0, 13'h0005, -1};
    vecs[2] = '{1'b1, 64'h2000, 13'h1ABC, 64'h1111_0000, 13'h0000, -1};
    vecs[3] = '{1'b0, 64'h2000, 13'h0ABC, 64'h1111_0000, 13'h0ABC, 2};
    vecs[4] = '{1'b1, 64'h8000, 13'h1001, 64'hB0, 13'h0000, -1};            // aliases to word 0
    vecs[5] = '{1'b0, 64'h0000, 13'h0002, 64'hB0, 13'h0002, -1};
    vecs[6] = '{1'b1, 64'h7FC0, 13'h1003, 64'hC0, 13'h0000, -1};            // last line
    vecs[7] = '{1'b0, 64'hFFFF_0000_0000_7FC7, 13'h0FFF, 64'hC0, 13'h0FFF, -1};
    vecs[8] = '{1'b0, 64'h1047, 13'h0123, 64'hA0, 13'h0123, -1};

    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wr) begin
        write_line(vecs[i].addr, vecs[i].tag, vecs[i].seed);
      end else begin
        push_line(vecs[i].seed);
        read_line(vecs[i].addr, vecs[i].tag, vecs[i].exp_tag, vecs[i].stall_beat, 1'b0);
      end
    end

    // reset mid-write: three committed beats survive, the rest of the old line stays
    write_line(64'h3000, 13'h1010, 64'hF0);
    send_beat(64'h3000, 13'h1011, c);
    write_data(64'hE0, 13'h1011, 3);
    bus_reqcyc = 1'b0;
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_wr");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) exp_q.push_back(64'hE0 + 64'(i));
    for (int i = 3; i < 8; i++) exp_q.push_back(64'hF0 + 64'(i));
    read_line(64'h3000, 13'h000A, 13'h000A, -1, 1'b0);

    // reset mid-read: respcyc drops asynchronously, next request served normally
    send_beat(64'h1040, 13'h0009, c);
    bus_reqcyc = 1'b0;
    for (int i = 0; i < 20 && !bus_respcyc; i++) begin
      @(posedge clk); #1;
    end
    check("rst_rd_respcyc_up", 64'(bus_respcyc), 64'd1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("rst_rd");
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    push_line(64'hA0);
    read_line(64'h1040, 13'h000B, 13'h000B, -1, 1'b0);

    // collision: write request raised during the read is held off until the last beat is accepted
    push_line(64'h1111_0000);
    read_line(64'h2000, 13'h0001, 13'h0001, -1, 1'b1);
    check("collide_ack_after_read", 64'(bus_reqack), 64'd0);
    @(posedge clk); #1;
    check("collide_ack_next_cycle", 64'(bus_reqack), 64'd1);
    check("collide_state_wr", 64'(o_dbg_state), 64'd1);
    write_data(64'h50, 13'h1007, 8);
    bus_reqcyc = 1'b0;
    @(posedge clk); #1;
    push_line(64'h50);
    read_line(64'h5000, 13'h0007, 13'h0007, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
